// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-granular memory copy engine.
package mem_copy_pkg;

    localparam int unsigned WORD_BYTES = 2;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_copy_ptr.sv
// Source/destination pointers, remaining-word counter and completed-word count
// for the copy engine. Loaded on job accept, stepped once per completed write.
module mem_copy_ptr
    import mem_copy_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] src_ptr,
    output logic [ADDR_W-1:0] dst_ptr,
    output logic [LEN_W-1:0]  words_copied,
    output logic              last
);

    logic [LEN_W-1:0] remaining;

    // Pointer and counter registers; pointer arithmetic wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            words_copied <= '0;
        end else if (load) begin
            src_ptr      <= src_addr;
            dst_ptr      <= dst_addr;
            remaining    <= len;
            words_copied <= '0;
        end else if (step) begin
            src_ptr      <= src_ptr + ADDR_W'(WORD_BYTES);
            dst_ptr      <= dst_ptr + ADDR_W'(WORD_BYTES);
            remaining    <= remaining - LEN_W'(1);
            words_copied <= words_copied + LEN_W'(1);
        end
    end

    // The write in progress is the final one of the job.
    always_comb begin
        last = (remaining == LEN_W'(1));
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the single-port 16-bit byte-addressable memory.
// Alternates READ and WRITE cycles word by word, optionally issues one
// createdump cycle, then pulses done.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              dump_on_done,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_copied,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic              mem_createdump
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] hold_reg;
    logic              dump_flag;
    logic              load;
    logic              step;
    logic              last;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;

    assign load = (state == ST_IDLE) && start && (len != '0);
    assign step = (state == ST_WRITE);

    mem_copy_ptr #(
        .LEN_W(LEN_W)
    ) u_ptr (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .src_ptr      (src_ptr),
        .dst_ptr      (dst_ptr),
        .words_copied (words_copied),
        .last         (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (len != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ:  next_state = ST_WRITE;
            ST_WRITE: begin
                if (last) begin
                    next_state = dump_flag ? ST_DUMP : ST_DONE;
                end else begin
                    next_state = ST_READ;
                end
            end
            ST_DUMP:  next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Read-data capture and dump request flag latched on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg  <= '0;
            dump_flag <= 1'b0;
        end else begin
            if (state == ST_READ) begin
                hold_reg <= mem_rdata;
            end
            if (load) begin
                dump_flag <= dump_on_done;
            end
        end
    end

    // Moore output decode from state and pointer registers.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_createdump = 1'b0;
        case (state)
            ST_READ: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_addr   = src_ptr;
            end
            ST_WRITE: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dst_ptr;
                mem_wdata  = hold_reg;
            end
            ST_DUMP: begin
                busy           = 1'b1;
                mem_createdump = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: byte-addressed memory model plus a
// scoreboard of expected bus cycles built from a reference copy of memory.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic        dump_on_done;
    logic        busy;
    logic        done;
    logic [15:0] words_copied;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_enable;
    logic        mem_wr;
    logic        mem_createdump;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(
        .LEN_W(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .dump_on_done   (dump_on_done),
        .busy           (busy),
        .done           (done),
        .words_copied   (words_copied),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_createdump (mem_createdump)
    );

    // Memory model: combinational read, write at the clock edge unless in reset.
    logic [15:0] addr_p1;
    always_comb begin
        addr_p1   = mem_addr + 16'd1;
        mem_rdata = {mem[mem_addr], mem[addr_p1]};
    end

    always @(posedge clk) begin
        if (!rst && mem_enable && mem_wr) begin
            mem[mem_addr] = mem_wdata[15:8];
            mem[addr_p1]  = mem_wdata[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [15:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                           input logic dmp, input logic poke_busy, input logic poke_done);
        int          exp_done;
        int          busy_last;
        logic [15:0] sa;
        logic [15:0] da;
        logic [15:0] a;
        txn_t        t;
        txn_t        got;

        // Build the expected bus cycles, copying forward through the reference memory.
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            sa     = s + 16'(2 * i);
            da     = d + 16'(2 * i);
            t.wr   = 1'b0;
            t.addr = sa;
            t.data = 16'h0000;
            exp_q.push_back(t);
            t.wr   = 1'b1;
            t.addr = da;
            t.data = {ref_mem[sa], ref_mem[sa + 16'd1]};
            exp_q.push_back(t);
            ref_mem[da]         = t.data[15:8];
            ref_mem[da + 16'd1] = t.data[7:0];
        end
        if (n == 16'd0) begin
            exp_done  = 1;
            busy_last = 0;
        end else begin
            exp_done  = 2 * int'(n) + 1 + int'(dmp);
            busy_last = 2 * int'(n) + int'(dmp);
        end

        @(negedge clk);
        start        = 1'b1;
        src_addr     = s;
        dst_addr     = d;
        len          = n;
        dump_on_done = dmp;

        for (int c = 1; c <= exp_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke_busy && c == 2) begin
                start    = 1'b1;
                len      = 16'd0;
                src_addr = 16'hDEAD;
            end
            if (poke_done && c == exp_done) start = 1'b1;

            chk("busy", busy, (c <= busy_last));
            chk("done", done, (c == exp_done));
            chk("createdump", mem_createdump, (n != 16'd0 && dmp && c == exp_done - 1));
            if (n != 16'd0 && dmp && c == exp_done - 1) begin
                a = d + 16'(2 * int'(n) - 2);
                chk("dump_enable", mem_enable, 1'b0);
                chk("dump_sees_write", {mem[a], mem[a + 16'd1]}, {ref_mem[a], ref_mem[a + 16'd1]});
            end
            if (mem_enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    chk("mem_wr", mem_wr, got.wr);
                    chk("mem_addr", mem_addr, got.addr);
                    if (got.wr) chk("mem_wdata", mem_wdata, got.data);
                end
            end else begin
                chk("idle_addr", mem_addr, 16'h0000);
                chk("idle_wdata", mem_wdata, 16'h0000);
                chk("idle_wr", mem_wr, 1'b0);
            end
        end

        if (poke_done) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                start = 1'b0;
                chk("done_start_busy", busy, 1'b0);
                chk("done_start_enable", mem_enable, 1'b0);
                chk("done_start_done", done, 1'b0);
            end
        end

        chk("queue_drained", exp_q.size(), 0);
        if (n != 16'd0) chk("words_copied", words_copied, n);
        for (int i = 0; i < 2 * int'(n); i++) begin
            a = d + 16'(i);
            chk("dst_byte", mem[a], ref_mem[a]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  basic_exp [0:5];
        logic [15:0] w0;

        basic_exp[0] = 8'h11; basic_exp[1] = 8'h22; basic_exp[2] = 8'h33;
        basic_exp[3] = 8'h44; basic_exp[4] = 8'h55; basic_exp[5] = 8'h66;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst          = 1'b1;
        start        = 1'b0;
        src_addr     = 16'h0000;
        dst_addr     = 16'h0000;
        len          = 16'h0000;
        dump_on_done = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_enable", mem_enable, 1'b0);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_dump", mem_createdump, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_words", words_copied, 16'h0000);
        rst = 1'b0;

        // Basic three-word copy.
        for (int i = 0; i < 6; i++) put_byte(16'h0100 + 16'(i), basic_exp[i]);
        run_job(16'h0100, 16'h0200, 16'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) chk("basic_dst", mem[16'h0200 + 16'(i)], basic_exp[i]);

        // Zero length: done in cycle 1, no traffic, words_copied holds.
        run_job(16'h0000, 16'h0300, 16'd0, 1'b0, 1'b0, 1'b0);
        chk("zero_len_words_hold", words_copied, 16'd3);

        // Source wraps past 0xFFFE; start pulsed mid-job must be ignored.
        put_byte(16'hFFFC, 8'hA1); put_byte(16'hFFFD, 8'hA2);
        put_byte(16'hFFFE, 8'hA3); put_byte(16'hFFFF, 8'hA4);
        put_byte(16'h0000, 8'hA5); put_byte(16'h0001, 8'hA6);
        run_job(16'hFFFC, 16'h1000, 16'd3, 1'b0, 1'b1, 1'b0);

        // Forward overlap replicates the source pattern.
        put_byte(16'h0100, 8'hAA); put_byte(16'h0101, 8'hBB);
        put_byte(16'h0102, 8'hCC); put_byte(16'h0103, 8'hDD);
        run_job(16'h0100, 16'h0102, 16'd2, 1'b0, 1'b0, 1'b0);
        chk("overlap_0", mem[16'h0102], 8'hAA);
        chk("overlap_1", mem[16'h0103], 8'hBB);
        chk("overlap_2", mem[16'h0104], 8'hAA);
        chk("overlap_3", mem[16'h0105], 8'hBB);

        // Single word with dump; start held in DONE must not be queued.
        run_job(16'h0200, 16'h0400, 16'd1, 1'b1, 1'b0, 1'b1);

        // Odd addresses and in-place copy.
        put_byte(16'h0301, 8'h5A); put_byte(16'h0302, 8'hC3);
        put_byte(16'h0303, 8'h96); put_byte(16'h0304, 8'h69);
        run_job(16'h0301, 16'h0501, 16'd2, 1'b0, 1'b0, 1'b0);
        run_job(16'h0200, 16'h0200, 16'd2, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 3 of a four-word job.
        for (int i = 0; i < 8; i++) put_byte(16'h0700 + 16'(i), 8'h10 + 8'(i));
        w0 = {ref_mem[16'h0700], ref_mem[16'h0701]};
        @(negedge clk);
        start    = 1'b1;
        src_addr = 16'h0700;
        dst_addr = 16'h0800;
        len      = 16'd4;
        dump_on_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("rstjob_c1_addr", mem_addr, 16'h0700);
        chk("rstjob_c1_wr", mem_wr, 1'b0);
        @(negedge clk);
        chk("rstjob_c2_addr", mem_addr, 16'h0800);
        chk("rstjob_c2_wdata", mem_wdata, w0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstjob_busy", busy, 1'b0);
        chk("rstjob_done", done, 1'b0);
        chk("rstjob_enable", mem_enable, 1'b0);
        chk("rstjob_wr", mem_wr, 1'b0);
        chk("rstjob_dump", mem_createdump, 1'b0);
        chk("rstjob_addr", mem_addr, 16'h0000);
        chk("rstjob_wdata", mem_wdata, 16'h0000);
        chk("rstjob_words", words_copied, 16'h0000);
        rst = 1'b0;
        chk("rstjob_partial_kept", {mem[16'h0800], mem[16'h0801]}, w0);
        chk("rstjob_no_second", {mem[16'h0802], mem[16'h0803]}, 16'h0000);
        ref_mem[16'h0800] = w0[15:8];
        ref_mem[16'h0801] = w0[7:0];

        // Recovery after reset, with dump.
        run_job(16'h0700, 16'h0900, 16'd2, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-granular block-copy initiator that drives the single-cycle, byte-addressable, 16-bit memory port from the requester side. On a start pulse it copies `len` 16-bit words from `src_addr` to `dst_addr` with strictly alternating read and write cycles, because the memory forbids a concurrent read and write. It optionally requests a memory dump on completion. It sits between the test/control logic and the memory, in place of direct processor access during bulk copies.

## Interface
- `LEN_W`, default 16: width of the word-count input and the progress counter.
- `clk` in 1: clock. Reset `rst` is synchronous, active-high.
- `rst` in 1: synchronous reset.
- `start` in 1: copy request; sampled only in IDLE.
- `src_addr` in 16: source byte address, latched on accept.
- `dst_addr` in 16: destination byte address, latched on accept.
- `len` in LEN_W: number of 16-bit words to copy, latched on accept.
- `dump_on_done` in 1: latched on accept; requests one createdump cycle at the end.
- `busy` out 1: high from the cycle after accept through the last READ/WRITE/DUMP cycle.
- `done` out 1: one-cycle completion pulse.
- `words_copied` out LEN_W: number of writes completed in the current or last job.
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: write data to the memory; high byte goes to `addr`, low byte to `addr+1`.
- `mem_rdata` in 16: combinational read data from the memory.
- `mem_enable` out 1: memory enable.
- `mem_wr` out 1: memory write.
- `mem_createdump` out 1: memory dump request.

## Operation
- States: IDLE, READ, WRITE, DUMP, DONE.
  - IDLE: if `start` is high and `len` != 0, latch the inputs, clear `words_copied`, go to READ.
  - IDLE: if `start` is high and `len` == 0, go to DONE. No memory traffic occurs.
  - READ: drive `mem_enable`=1, `mem_wr`=0, `mem_addr`=src_ptr. Capture `mem_rdata` into hold_reg at the clock edge, then go to WRITE.
  - WRITE: drive `mem_enable`=1, `mem_wr`=1, `mem_addr`=dst_ptr, `mem_wdata`=hold_reg.
  - WRITE, at the clock edge: src_ptr += 2, dst_ptr += 2, remaining -= 1, `words_copied` += 1.
  - WRITE exit: if remaining was 1, go to DUMP when the dump flag is set, otherwise to DONE. Otherwise go back to READ.
  - DUMP: `mem_createdump`=1, `mem_enable`=0, then go to DONE.
  - DONE: `done`=1, then go to IDLE.
- Memory outputs are Moore-decoded from the state and pointer registers. In IDLE, DONE and DUMP, `mem_addr`=0 and `mem_wdata`=0.
- `start` is ignored in every state except IDLE. In DONE it is not queued.
- Pointer arithmetic is 16-bit modulo: 0xFFFE + 2 = 0x0000. Odd addresses are legal and passed through unchanged.
- Overlap: the copy is forward and word-by-word. If `dst_addr` lies within (`src_addr`, `src_addr`+2·len), the source pattern replicates; this is the specified behaviour. `dst_addr`==`src_addr` rewrites identical data.
- `words_copied` holds its value after DONE until the next accept.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_enable`, `mem_wr`, `mem_createdump` = 0; `mem_addr`, `mem_wdata`, `words_copied`, internal pointers, hold_reg = 0.
- `start` is accepted at edge E0. READ occupies cycle 1, WRITE cycle 2, and so on.
- For N words, traffic occupies cycles 1..2N.
  - Without dump: `done` is high in cycle 2N+1.
  - With dump: DUMP is cycle 2N+1 and `done` is high in cycle 2N+2.
- `len`=0: `done` is high in cycle 1 and `busy` never rises.
- A new job can be accepted in the cycle after `done`. Minimum job-to-job gap is 1 IDLE cycle.
- `rst` mid-job returns to IDLE at that edge and all outputs are at reset values in the next cycle. A write presented in the reset cycle is discarded by the memory. A partial copy is not rolled back.

## Structure
- Shared package `mem_copy_pkg`: state encoding constants, WORD_BYTES=2, ADDR_W=16, DATA_W=16.
- One sub-module, `mem_copy_ptr`: src/dst pointers, remaining counter and `words_copied`, with load/step controls driven by the FSM in `mem_copy_engine`.

## Test plan
- Basic copy: preload 0x0100..0x0105 = 11 22 33 44 55 66; src=0x0100, dst=0x0200, len=3 -> 0x0200..0x0205 = 11 22 33 44 55 66; `done` in cycle 7; `words_copied`=3.
- Zero length: len=0 -> `done` in cycle 1; `mem_enable` never high; `busy` stays 0.
- Wrap: src=0xFFFC, dst=0x1000, len=3 -> reads 0xFFFC, 0xFFFE, 0x0000; destination matches bytewise.
- Overlap: src=0x0100 holding AABB CCDD, dst=0x0102, len=2 -> 0x0102..0x0105 = AA BB AA BB.
- Dump: dump_on_done=1, len=1 -> `mem_createdump` high in cycle 3 with `mem_enable`=0; `done` in cycle 4; dumpfile reflects the write.
- Reset mid-job: len=4, assert `rst` in cycle 3 -> next cycle IDLE with all outputs 0; `start` is ignored while busy, and a second `start` in DONE is not queued.
